mcp3008_responder: RTL and testbench
====================================

Name: mcp3008_responder

Overview:
Synthesizable SPI responder that emulates an MCP3008-style 8-channel 10-bit ADC on the Pmod ADC interface (AD_CLK/CS/DIN/DOUT).
- Serves as the far-end partner of the on-board ADC master in loopback and emulation builds.
- Oversamples the SPI pins in the system clock domain, decodes start/SGL/D2..D0, and requests a sample from a local data source.
- Shifts out a null bit and then the 10-bit result, MSB first, with an optional LSB-first tail.

Parameters:
SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/mosi (minimum 2)
LSB_TAIL, 1, 1 = after B0 keep shifting B1..B9 LSB-first, then zeros; 0 = zeros after B0
RESET_DATA, 10'd0, value held in the sample register after reset

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock from master (AD_CLK); asynchronous
cs_n  in  1  chip select from master (CS), active low; asynchronous
mosi  in  1  master data (DIN); asynchronous
miso  out  1  responder data (DOUT)
miso_oe  out  1  output enable for the DOUT pad buffer
conv_req  out  1  one-cycle pulse when the channel/mode decode completes
conv_ch  out  3  decoded channel {D2,D1,D0}; valid from conv_req until the next conv_req
conv_sgl  out  1  decoded mode, 1 = single-ended; same validity as conv_ch
conv_ack  in  1  source strobe: conv_data is valid this cycle
conv_data  in  10  sample value from the local source
frame_done  out  1  one-cycle pulse when a frame ends (cs_n rising detected)
late_err  out  1  one-cycle pulse when the null bit is launched without conv_ack having been seen

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, miso = 0, miso_oe = 0, conv_req = 0, conv_ch = 0, conv_sgl = 0, frame_done = 0, late_err = 0, sample register = RESET_DATA, bit counter = 0.
- Synchronization: sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rise/fall detectors act on the last stage, so pin-to-action latency is SYNC_STAGES+1 clk cycles.
  - mosi is taken from the same stage as sclk, keeping the two aligned.
- cs_n sync high forces IDLE from any state on that cycle, with miso_oe = 0 and miso = 0.
  - If the state was not IDLE, frame_done pulses on the same cycle.
  - cs_n high has priority over any simultaneous sclk edge.
- States and transitions:
  - IDLE: on cs_n sync low -> WAIT_START.
  - WAIT_START: on each sclk rise, sample mosi. 0 -> stay (leading zeros ignored); 1 -> CFG with counter = 0.
  - CFG: on each sclk rise, shift mosi into cfg[3:0] in the order SGL, D2, D1, D0.
    - On the 4th rise: conv_sgl = SGL, conv_ch = {D2,D1,D0}, conv_req pulses the next cycle, clear ack_seen -> SAMPLE.
  - SAMPLE: conv_ack high in any cycle loads conv_data into the sample register and sets ack_seen.
    - On the next sclk fall: drive miso = 0 (null bit), miso_oe = 1.
    - If ack_seen = 0 at that fall, late_err pulses and the previous sample register value is used.
    - Sample register is frozen from this point; conv_ack is ignored until the next SAMPLE state.
    - Set counter = 9 -> MSB.
  - MSB: on each sclk fall, miso = sample[counter], then decrement; B9 is output on the first fall after the null bit.
    - After B0 is driven: LSB_TAIL = 1 -> LSB with counter = 1; otherwise -> ZERO.
  - LSB: on each sclk fall, miso = sample[counter], then increment; after B9 is driven -> ZERO.
  - ZERO: miso = 0 on every fall; remain here until cs_n rises.
- miso changes only on synchronized sclk falls or on cs_n rise/reset. mosi is read only on synchronized sclk rises.
- Extra sclk edges in IDLE are ignored.
- Reset asserted mid-frame returns all outputs to reset values immediately. After release, a frame whose cs_n is already low starts in WAIT_START.
- A new cs_n fall after a frame always restarts decode; no state carries over except the sample register.

Test Plan:
- Single-ended ch0, conv_ack with conv_data = 10'h2A5 after conv_req, 16 sclk -> conv_req once, conv_ch = 0, conv_sgl = 1; miso after the start bit reads null 0 then 1010100101; late_err = 0; frame_done at cs_n rise.
- Three leading zeros then start, differential ch5 (SGL = 0, D = 101), data = 10'h3FF -> conv_ch = 5, conv_sgl = 0; output 0 then ten 1s.
- No conv_ack, previous sample = 10'h155 -> late_err pulses once at the null bit; output 0101010101.
- LSB_TAIL = 1, data = 10'h001, 30 sclk -> MSB field 0000000001, tail B1..B9 = 000000000, then zeros; with LSB_TAIL = 0, zeros directly after B0.
- cs_n raised after the 6th data bit, then a new frame for ch3 -> miso_oe = 0 within SYNC_STAGES+1 cycles, frame_done pulses, second frame decodes ch3 correctly.
- rst_n pulsed low mid-MSB with cs_n held low -> outputs reach reset values asynchronously; after release the bench sends a full frame and gets a correct decode.

Source files
------------

// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI ADC responder. The SPI pins are oversampled in the clk domain.
// It decodes start/SGL/D2..D0, requests a sample, and shifts out null + 10 bits MSB first.
module mcp3008_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LSB_TAIL    = 1,
    parameter logic [9:0]  RESET_DATA  = 10'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       conv_req,
    output logic [2:0] conv_ch,
    output logic       conv_sgl,
    input  logic       conv_ack,
    input  logic [9:0] conv_data,
    output logic       frame_done,
    output logic       late_err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, CFG, SAMPLE, MSB, LSB, ZERO
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d;
    logic                   sclk_s, cs_s, mosi_s, rise, fall;

    logic [3:0] cnt, cnt_n;
    logic [2:0] cfg, cfg_n;
    logic [9:0] sample, sample_n;
    logic       ack_seen, ack_seen_n;
    logic       miso_n, oe_n, req_n, sgl_n, done_n, late_n;
    logic [2:0] ch_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    // mosi comes from the same stage as sclk so a rise always sees the matching data bit
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cfg        <= '0;
            sample     <= RESET_DATA;
            ack_seen   <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            conv_req   <= 1'b0;
            conv_ch    <= '0;
            conv_sgl   <= 1'b0;
            frame_done <= 1'b0;
            late_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            cfg        <= cfg_n;
            sample     <= sample_n;
            ack_seen   <= ack_seen_n;
            miso       <= miso_n;
            miso_oe    <= oe_n;
            conv_req   <= req_n;
            conv_ch    <= ch_n;
            conv_sgl   <= sgl_n;
            frame_done <= done_n;
            late_err   <= late_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cfg_n      = cfg;
        sample_n   = sample;
        ack_seen_n = ack_seen;
        miso_n     = miso;
        oe_n       = miso_oe;
        req_n      = 1'b0;
        ch_n       = conv_ch;
        sgl_n      = conv_sgl;
        done_n     = 1'b0;
        late_n     = 1'b0;

        if (cs_s) begin
            state_n = IDLE;
            miso_n  = 1'b0;
            oe_n    = 1'b0;
            done_n  = (state != IDLE);
        end else begin
            case (state)
                IDLE: state_n = WAIT_START;
                WAIT_START: begin
                    if (rise && mosi_s) begin
                        state_n = CFG;
                        cnt_n   = '0;
                    end
                end
                CFG: begin
                    if (rise) begin
                        cfg_n = {cfg[1:0], mosi_s};
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd3) begin
                            sgl_n      = cfg[2];
                            ch_n       = {cfg[1:0], mosi_s};
                            req_n      = 1'b1;
                            ack_seen_n = 1'b0;
                            state_n    = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (fall) begin
                        // an ack coinciding with the null-bit fall still counts as on time
                        miso_n  = 1'b0;
                        oe_n    = 1'b1;
                        cnt_n   = 4'd9;
                        state_n = MSB;
                        if (conv_ack)
                            sample_n = conv_data;
                        else if (!ack_seen)
                            late_n = 1'b1;
                    end else if (conv_ack) begin
                        sample_n   = conv_data;
                        ack_seen_n = 1'b1;
                    end
                end
                MSB: begin
                    if (fall) begin
                        miso_n = sample[cnt];
                        if (cnt == 4'd0) begin
                            if (LSB_TAIL != 0) begin
                                state_n = LSB;
                                cnt_n   = 4'd1;
                            end else begin
                                state_n = ZERO;
                            end
                        end else begin
                            cnt_n = cnt - 4'd1;
                        end
                    end
                end
                LSB: begin
                    if (fall) begin
                        miso_n = sample[cnt];
                        if (cnt == 4'd9)
                            state_n = ZERO;
                        else
                            cnt_n = cnt + 4'd1;
                    end
                end
                ZERO: begin
                    if (fall)
                        miso_n = 1'b0;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: a mode-0 SPI master plus a conversion source.
// Expected miso bits are queued per frame and popped on each master sample.
module tb_mcp3008_responder;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, mosi, conv_ack;
    logic [9:0] conv_data;

    logic       miso, miso_oe, conv_req, conv_sgl, frame_done, late_err;
    logic [2:0] conv_ch;
    logic       miso_b, miso_oe_b, conv_req_b, conv_sgl_b, frame_done_b, late_err_b;
    logic [2:0] conv_ch_b;

    mcp3008_responder #(.SYNC_STAGES(2), .LSB_TAIL(1), .RESET_DATA(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .conv_req(conv_req), .conv_ch(conv_ch),
        .conv_sgl(conv_sgl), .conv_ack(conv_ack), .conv_data(conv_data),
        .frame_done(frame_done), .late_err(late_err)
    );

    mcp3008_responder #(.SYNC_STAGES(2), .LSB_TAIL(0), .RESET_DATA(10'd0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso_b), .miso_oe(miso_oe_b), .conv_req(conv_req_b), .conv_ch(conv_ch_b),
        .conv_sgl(conv_sgl_b), .conv_ack(conv_ack), .conv_data(conv_data),
        .frame_done(frame_done_b), .late_err(late_err_b)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         req_cnt, late_cnt, done_cnt;
    logic [2:0] seen_ch;
    logic       seen_sgl;
    bit         ack_en;
    logic [9:0] ack_data;
    logic       q_a[$];
    logic       q_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k = 0 is the null bit, 1..10 are B9..B0, 11..19 the optional B1..B9 tail
    function automatic logic exp_bit(input logic [9:0] d, input int k, input bit tail);
        int idx;
        if (k == 0) return 1'b0;
        if (k <= 10) begin
            idx = 10 - k;
            return d[idx];
        end
        if (tail && k <= 19) begin
            idx = k - 10;
            return d[idx];
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        conv_ack = 1'b0;
        if (conv_req) begin
            req_cnt++;
            seen_ch  = conv_ch;
            seen_sgl = conv_sgl;
            if (ack_en) begin
                conv_ack  = 1'b1;
                conv_data = ack_data;
            end
        end
        if (late_err)   late_cnt++;
        if (frame_done) done_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame(input int lead, input logic sgl, input logic [2:0] ch, input int nclk,
                         input logic [9:0] data, input bit ack, input bit raise);
        int         first;
        logic [4:0] hdr;
        logic       ea, eb;
        first    = lead + 5;
        hdr      = {1'b1, sgl, ch};
        req_cnt  = 0;
        late_cnt = 0;
        done_cnt = 0;
        ack_en   = ack;
        ack_data = data;
        for (int k = 0; k < nclk - first; k++) begin
            q_a.push_back(exp_bit(data, k, 1'b1));
            q_b.push_back(exp_bit(data, k, 1'b0));
        end
        cs_n = 1'b0;
        ticks(8);
        for (int i = 0; i < nclk; i++) begin
            if (i < lead || i >= first) mosi = 1'b0;
            else                        mosi = hdr[4 - (i - lead)];
            ticks(8);
            if (i >= first) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                check($sformatf("miso_tail[%0d]", i - first), miso, ea);
                check($sformatf("miso_notail[%0d]", i - first), miso_b, eb);
                check($sformatf("miso_oe[%0d]", i - first), miso_oe, 1);
            end
            sclk = 1'b1;
            ticks(8);
            sclk = 1'b0;
        end
        ticks(8);
        check("conv_req_count", req_cnt, 1);
        check("conv_ch", seen_ch, ch);
        check("conv_sgl", seen_sgl, sgl);
        check("late_err_count", late_cnt, ack ? 0 : 1);
        if (raise) begin
            cs_n = 1'b1;
            ticks(3);
            check("miso_oe_after_cs", miso_oe, 0);
            check("miso_after_cs", miso, 0);
            ticks(5);
            check("frame_done_count", done_cnt, 1);
        end
        ack_en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        conv_ack  = 1'b0;
        conv_data = '0;
        ack_en    = 1'b0;
        ack_data  = '0;
        ticks(3);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_conv_req", conv_req, 0);
        check("rst_conv_ch", conv_ch, 0);
        check("rst_conv_sgl", conv_sgl, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_late_err", late_err, 0);
        rst_n = 1'b1;
        ticks(4);

        frame(0, 1'b1, 3'd0, 16, 10'h2A5, 1'b1, 1'b1);
        frame(3, 1'b0, 3'd5, 19, 10'h3FF, 1'b1, 1'b1);
        frame(0, 1'b1, 3'd2, 16, 10'h155, 1'b1, 1'b1);
        frame(0, 1'b1, 3'd2, 16, 10'h155, 1'b0, 1'b1);
        frame(0, 1'b1, 3'd7, 30, 10'h001, 1'b1, 1'b1);
        frame(0, 1'b0, 3'd1, 30, 10'h2A5, 1'b1, 1'b1);
        frame(0, 1'b1, 3'd6, 12, 10'h3C3, 1'b1, 1'b1);
        frame(0, 1'b1, 3'd3, 16, 10'h0AB, 1'b1, 1'b1);

        frame(0, 1'b1, 3'd4, 10, 10'h1F0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        check("async_rst_miso", miso, 0);
        check("async_rst_miso_oe", miso_oe, 0);
        check("async_rst_conv_ch", conv_ch, 0);
        check("async_rst_conv_sgl", conv_sgl, 0);
        check("async_rst_miso_notail", miso_b, 0);
        ticks(3);
        rst_n = 1'b1;
        ticks(4);
        frame(0, 1'b1, 3'd1, 16, 10'h000, 1'b0, 1'b1);
        frame(0, 1'b0, 3'd3, 16, 10'h2D2, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
